div_iter: RTL

//   Iterative restoring divider, parametrised in operand width and bits retired per cycle.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 24 ++
 rtl/div_iter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and latency helper for the iterative divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } state_t;

  // Cycles from the accepting edge to the done cycle on the normal path.
  function automatic int div_latency(input int width, input int k);
    return width / k + 2;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted;
  logic             q_bit;

  // The dividend's next bit comes off the top of the quotient register as the
  // quotient bit enters at the bottom.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[WIDTH:0] - divisor) : shifted[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative signed/unsigned restoring divider with start/busy/done
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             div_zero,
  output logic             overflow
);

  localparam int STEPS = WIDTH / K;
  localparam int CW    = $clog2(STEPS) + 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic [WIDTH:0]   rem_q, dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q, sign_r;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH:0]   abs_b;
  logic             b_zero, ovf_case, last_iter;

  logic [WIDTH:0]   chain_rem [0:K];
  logic [WIDTH-1:0] chain_quo [0:K];

  always_comb begin
    neg_a     = signed_q & a_q[WIDTH-1];
    neg_b     = signed_q & b_q[WIDTH-1];
    // |MIN_INT| read as unsigned is exactly 2^(WIDTH-1), so WIDTH bits suffice here.
    abs_a     = neg_a ? (~a_q + 1'b1) : a_q;
    abs_b     = neg_b ? -{b_q[WIDTH-1], b_q} : {1'b0, b_q};
    b_zero    = (b_q == '0);
    ovf_case  = signed_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    last_iter = (cnt_q == CW'(STEPS - 1));
  end

  assign chain_rem[0] = rem_q;
  assign chain_quo[0] = quo_q;

  for (genvar k = 0; k < K; k++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (chain_rem[k]),
      .quo_in  (chain_quo[k]),
      .divisor (dvs_q),
      .rem_out (chain_rem[k+1]),
      .quo_out (chain_quo[k+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: state_d = (b_zero || ovf_case) ? FIX : ITER;
      ITER: if (last_iter) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIX);
  end

  // Results are registered on the edge entering FIX so they are valid alongside done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      high     <= '0;
      low      <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= is_signed;
          end
        end
        PREP: begin
          rem_q  <= '0;
          quo_q  <= abs_a;
          dvs_q  <= abs_b;
          cnt_q  <= '0;
          sign_q <= neg_a ^ neg_b;
          sign_r <= neg_a;
          if (b_zero) begin
            low      <= '1;
            high     <= a_q;
            div_zero <= 1'b1;
            overflow <= 1'b0;
          end else if (ovf_case) begin
            low      <= a_q;
            high     <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b1;
          end
        end
        ITER: begin
          rem_q <= chain_rem[K];
          quo_q <= chain_quo[K];
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            low      <= sign_q ? -chain_quo[K] : chain_quo[K];
            high     <= sign_r ? -chain_rem[K][WIDTH-1:0] : chain_rem[K][WIDTH-1:0];
            div_zero <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
